// File: rtl/garo_move_mux_if.sv
// Bundles the stop control, move code and the random/damage/accuracy results
// between the battle controller (master) and garo_move_mux (slave).
interface garo_move_mux_if #(
    parameter int RNG_BITS = 6
);
    logic                stop;
    logic [1:0]          pl_move;
    logic [RNG_BITS-1:0] random;
    logic [3:0]          dmg;
    logic [3:0]          accu;

    modport master (output stop, pl_move, input random, dmg, accu);
    modport slave  (input stop, pl_move, output random, dmg, accu);
endinterface

// File: rtl/garo_move_mux.sv
// Bank of Galois-LFSR random lanes plus the move damage/accuracy table.
// Optional macro MOVE_REG_EN registers dmg/accu (1-cycle latency, reset to 0).
module garo_move_mux #(
    parameter int          RNG_BITS = 6,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input logic            clk,
    input logic            rst,
    garo_move_mux_if.slave bus
);

    // An all-zero LFSR would lock up, so a zero seed falls back to 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lane_q [RNG_BITS];
    logic [15:0] lane_d [RNG_BITS];

    function automatic logic [15:0] rotl16(input logic [15:0] v, input int n);
        rotl16 = (v << n) | (v >> (16 - n));
    endfunction

    // Galois form of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [7:0] move_lut(input logic [1:0] code);
        case (code)
            2'b00: move_lut = {4'd3,  4'd15};
            2'b01: move_lut = {4'd5,  4'd12};
            2'b10: move_lut = {4'd8,  4'd8};
            2'b11: move_lut = {4'd12, 4'd4};
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < RNG_BITS; i++) begin
            if (rst) begin
                lane_d[i] = rotl16(SEED_EFF, i);
            end else if (bus.stop) begin
                lane_d[i] = lane_q[i];
            end else begin
                lane_d[i] = lfsr_step(lane_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        lane_q <= lane_d;
    end

    // Lane state is already a register, so its bit 0 is the registered output.
    always_comb begin
        for (int i = 0; i < RNG_BITS; i++) begin
            bus.random[i] = lane_q[i][0];
        end
    end

`ifdef MOVE_REG_EN
    logic [3:0] dmg_q, dmg_d;
    logic [3:0] accu_q, accu_d;

    always_comb begin
        {dmg_d, accu_d} = move_lut(bus.pl_move);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmg_q  <= 4'd0;
            accu_q <= 4'd0;
        end else begin
            dmg_q  <= dmg_d;
            accu_q <= accu_d;
        end
    end

    assign bus.dmg  = dmg_q;
    assign bus.accu = accu_q;
`else
    assign {bus.dmg, bus.accu} = move_lut(bus.pl_move);
`endif

endmodule

// File: tb/tb_garo_move_mux.sv
// Randomized bench for garo_move_mux against a lane-array reference model.
module tb_garo_move_mux;
    localparam int          RNG_BITS = 6;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    garo_move_mux_if #(.RNG_BITS(RNG_BITS)) bus ();

    garo_move_mux #(.RNG_BITS(RNG_BITS), .SEED(SEED)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] m [RNG_BITS];
    logic [3:0]  dmg_tab  [4] = '{4'd3, 4'd5, 4'd8, 4'd12};
    logic [3:0]  accu_tab [4] = '{4'd15, 4'd12, 4'd8, 4'd4};
    logic [3:0]  exp_dmg_reg, exp_accu_reg;
    logic [RNG_BITS-1:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] seed_of(input int i);
        logic [31:0] t;
        t = {SEED, SEED} << i;
        return t[31:16];
    endfunction

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] r;
        r = s / 2;
        if (s % 2 == 1) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic logic [RNG_BITS-1:0] model_bits();
        logic [RNG_BITS-1:0] b;
        for (int i = 0; i < RNG_BITS; i++) b[i] = m[i][0];
        return b;
    endfunction

    // One clock edge, with the reference model advanced using the inputs in force at that edge.
    task automatic step_edge();
        logic       r, s;
        logic [1:0] pm;
        r  = rst;
        s  = bus.stop;
        pm = bus.pl_move;
        @(posedge clk);
        #1;
        for (int i = 0; i < RNG_BITS; i++) begin
            if (r) m[i] = seed_of(i);
            else if (!s) m[i] = model_step(m[i]);
        end
        if (r) begin
            exp_dmg_reg  = 4'd0;
            exp_accu_reg = 4'd0;
        end else begin
            exp_dmg_reg  = dmg_tab[pm];
            exp_accu_reg = accu_tab[pm];
        end
    endtask

    task automatic chk_move(input string tag);
`ifdef MOVE_REG_EN
        chk({tag, "_dmg"},  bus.dmg,  exp_dmg_reg);
        chk({tag, "_accu"}, bus.accu, exp_accu_reg);
`else
        chk({tag, "_dmg"},  bus.dmg,  dmg_tab[bus.pl_move]);
        chk({tag, "_accu"}, bus.accu, accu_tab[bus.pl_move]);
`endif
    endtask

    initial begin
        bus.stop    = 1'b0;
        bus.pl_move = 2'd0;
        rst         = 1'b1;

        // Reset state
        step_edge();
        chk("rst_rand0", bus.random[0], 1'b1);
        chk("rst_rand1", bus.random[1], 1'b1);
        chk("rst_rand_all", bus.random, model_bits());
        chk_move("rst_move");

        // First step after reset
        rst = 1'b0;
        step_edge();
        chk("first_lane0", dut.lane_q[0], 16'hE270);
        chk("first_rand0", bus.random[0], 1'b0);
        chk("first_rand_all", bus.random, model_bits());

        // 200 free-running cycles with random move codes
        for (int c = 0; c < 200; c++) begin
            bus.pl_move = 2'($urandom_range(0, 3));
            #1;
            chk_move("run_move_pre");
            step_edge();
            chk("run_rand", bus.random, model_bits());
            chk_move("run_move_post");
        end

        // Stall for 10 cycles: outputs must hold
        held     = bus.random;
        bus.stop = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step_edge();
            chk("stall_hold", bus.random, held);
            chk("stall_model", bus.random, model_bits());
        end
        bus.stop = 1'b0;

        // Resume with random stop pulses
        for (int c = 0; c < 60; c++) begin
            bus.stop    = ($urandom_range(0, 3) == 0);
            bus.pl_move = 2'($urandom_range(0, 3));
            step_edge();
            chk("resume_rand", bus.random, model_bits());
            chk_move("resume_move");
        end
        bus.stop = 1'b0;

        // Directed table sweep
        for (int k = 0; k < 4; k++) begin
            bus.pl_move = 2'(k);
            #1;
`ifndef MOVE_REG_EN
            chk("sweep_dmg",  bus.dmg,  dmg_tab[k]);
            chk("sweep_accu", bus.accu, accu_tab[k]);
`endif
            step_edge();
            chk("sweep_dmg_reg",  bus.dmg,  dmg_tab[k]);
            chk("sweep_accu_reg", bus.accu, accu_tab[k]);
        end

        // Reset while stalled reloads the seeds
        bus.stop = 1'b1;
        step_edge();
        rst = 1'b1;
        step_edge();
        chk("rst_stop_rand", bus.random, model_bits());
        chk("rst_stop_lane1", dut.lane_q[1], 16'h59C3);
        chk_move("rst_stop_move");
        rst      = 1'b0;
        bus.stop = 1'b0;

        // Full period on lane 0
        for (int c = 0; c < 65535; c++) begin
            step_edge();
            chk("period_rand", bus.random, model_bits());
            chk("period_nonzero", (dut.lane_q[0] != 16'h0000), 1'b1);
        end
        chk("period_lane0", dut.lane_q[0], SEED);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
